// File: rtl/occ_pkg.sv
// Shared types and helpers for the occupancy gate controller.
package occ_pkg;

   typedef enum logic {IDLE, OPEN} state_t;

   localparam int unsigned CNT_W_DEF = 8;

   // Counts set bits of an up-to-8-bit door vector (narrower vectors are zero-extended).
   function automatic int unsigned popcount(input logic [7:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_DOORS = 4,
   parameter int unsigned IDX_W   = $clog2(N_DOORS)
) (
   input  logic [N_DOORS-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [N_DOORS-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               valid
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      valid   = 1'b0;
      idx     = '0;
      for (int unsigned off = 0; off < N_DOORS; off++) begin
         idx = IDX_W'((32'(ptr) + off) % N_DOORS);
         if (!valid && req[idx]) begin
            valid    = 1'b1;
            gnt_idx  = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/occupancy_gate_controller.sv
// Multi-door admission controller: round-robin grant, unlock/pass/timeout sequence,
// and the authoritative occupancy count netted against exits every cycle.
module occupancy_gate_controller
   import occ_pkg::*;
#(
   parameter int unsigned N_DOORS     = 4,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned OPEN_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_DOORS-1:0] entry_req,
   input  logic [N_DOORS-1:0] pass_sensor,
   input  logic [N_DOORS-1:0] exit_evt,
   input  logic [CNT_W-1:0]   max_occupancy,
   output logic [N_DOORS-1:0] door_unlock,
   output logic [CNT_W-1:0]   occupancy,
   output logic               full,
   output logic               busy,
   output logic               timeout_err,
   output logic               underflow_err
);

   localparam int unsigned IDX_W = $clog2(N_DOORS);
   localparam int unsigned TMR_W = $clog2(OPEN_CYCLES);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   rr_ptr, g_idx, arb_idx;
   logic [N_DOORS-1:0] arb_gnt;
   logic               arb_valid;
   logic [TMR_W-1:0]   timer;

   logic               grant_load, inc, timeout_nxt, underflow_nxt;
   logic [CNT_W+1:0]   exit_cnt;
   logic signed [CNT_W+1:0] occ_sum;
   logic [CNT_W-1:0]   occ_nxt;

   rr_arbiter #(
      .N_DOORS (N_DOORS),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req     (entry_req),
      .ptr     (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .valid   (arb_valid)
   );

   assign full = (occupancy >= max_occupancy);
   assign busy = (state == OPEN);

   always_comb begin
      state_nxt   = state;
      grant_load  = 1'b0;
      inc         = 1'b0;
      timeout_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (arb_valid && (occupancy < max_occupancy)) begin
               state_nxt  = OPEN;
               grant_load = 1'b1;
            end
         end
         OPEN: begin
            // Pass on the final timer cycle takes priority over the timeout.
            if (pass_sensor[g_idx]) begin
               inc       = 1'b1;
               state_nxt = IDLE;
            end else if (timer == TMR_W'(OPEN_CYCLES - 1)) begin
               timeout_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pass commit and exits are netted in one signed update, then clamped/saturated.
   always_comb begin
      exit_cnt      = (CNT_W + 2)'(popcount(8'(exit_evt)));
      occ_sum       = $signed({2'b00, occupancy}) + $signed({{(CNT_W + 1){1'b0}}, inc})
                      - $signed(exit_cnt);
      underflow_nxt = 1'b0;
      occ_nxt       = occ_sum[CNT_W-1:0];
      if (occ_sum[CNT_W+1]) begin
         occ_nxt       = '0;
         underflow_nxt = 1'b1;
      end else if (occ_sum[CNT_W]) begin
         occ_nxt = '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         g_idx         <= '0;
         timer         <= '0;
         door_unlock   <= '0;
         occupancy     <= '0;
         timeout_err   <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         state         <= state_nxt;
         occupancy     <= occ_nxt;
         timeout_err   <= timeout_nxt;
         underflow_err <= underflow_nxt;
         if (grant_load) begin
            g_idx       <= arb_idx;
            door_unlock <= arb_gnt;
            timer       <= '0;
            rr_ptr      <= (arb_idx == IDX_W'(N_DOORS - 1)) ? '0 : arb_idx + 1'b1;
         end else if (state == OPEN) begin
            if (state_nxt == IDLE) begin
               door_unlock <= '0;
            end
            timer <= timer + 1'b1;
         end
      end
   end

endmodule
